// File: rtl/snake_vga_compositor.sv
// Snake game pixel compositor: layers border, food, body, head and a blinking
// ROM-backed game-over overlay into RGB565 with a fixed two-cycle latency.
module snake_vga_compositor #(
    parameter int unsigned CW           = 11,
    parameter int unsigned H_DISP       = 800,
    parameter int unsigned V_DISP       = 600,
    parameter int unsigned BLOCK_W      = 10,
    parameter int unsigned BORDER_W     = 0,
    parameter int unsigned TXT_X0       = 292,
    parameter int unsigned TXT_Y0       = 168,
    parameter int unsigned TXT_W        = 216,
    parameter int unsigned TXT_H        = 64,
    parameter int unsigned AW           = 11,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [15:0] C_BG         = 16'hFFFF,
    parameter logic [15:0] C_BORDER     = 16'h001F,
    parameter logic [15:0] C_HEAD       = 16'h001F,
    parameter logic [15:0] C_BODY       = 16'hF800,
    parameter logic [15:0] C_FOOD       = 16'h07E0,
    parameter logic [15:0] C_TXT        = 16'h0000
) (
    input  logic          vga_clk,
    input  logic          sys_rst,
    input  logic [CW-1:0] pixel_xpos,
    input  logic [CW-1:0] pixel_ypos,
    input  logic [CW-1:0] head_x,
    input  logic [CW-1:0] head_y,
    input  logic [CW-1:0] food_x,
    input  logic [CW-1:0] food_y,
    input  logic          body_hit,
    input  logic          fin,
    output logic [AW-1:0] osd_addr,
    input  logic [7:0]    osd_q,
    output logic [15:0]   pixel_data,
    output logic          blink_on
);
    localparam int unsigned XW  = CW + 1;
    localparam int unsigned BW  = AW + 3;
    localparam int unsigned FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // One extra bit keeps object_x + BLOCK_W from wrapping at the screen edge.
    logic [XW-1:0] x_w, y_w, dx_w, dy_w;
    logic [BW-1:0] b_c;
    logic          in_txt_c, act_c, brd_c, head_c, food_c, tick_c;

    assign x_w  = {1'b0, pixel_xpos};
    assign y_w  = {1'b0, pixel_ypos};
    assign dx_w = x_w - XW'(TXT_X0);
    assign dy_w = y_w - XW'(TXT_Y0);

    assign in_txt_c = (x_w >= XW'(TXT_X0)) && (x_w < XW'(TXT_X0 + TXT_W)) &&
                      (y_w >= XW'(TXT_Y0)) && (y_w < XW'(TXT_Y0 + TXT_H));
    assign b_c      = BW'(dy_w) * BW'(TXT_W) + BW'(dx_w);
    assign osd_addr = in_txt_c ? b_c[BW-1:3] : '0;

    assign act_c  = (x_w < XW'(H_DISP)) && (y_w < XW'(V_DISP));
    assign head_c = (x_w >= {1'b0, head_x}) && (x_w < {1'b0, head_x} + XW'(BLOCK_W)) &&
                    (y_w >= {1'b0, head_y}) && (y_w < {1'b0, head_y} + XW'(BLOCK_W));
    assign food_c = (x_w >= {1'b0, food_x}) && (x_w < {1'b0, food_x} + XW'(BLOCK_W)) &&
                    (y_w >= {1'b0, food_y}) && (y_w < {1'b0, food_y} + XW'(BLOCK_W));
    assign tick_c = (x_w == XW'(H_DISP - 1)) && (y_w == XW'(V_DISP - 1));

    generate
        if (BORDER_W == 0) begin : gen_no_brd
            assign brd_c = 1'b0;
        end else begin : gen_brd
            assign brd_c = (x_w < XW'(BORDER_W)) || (x_w >= XW'(H_DISP - BORDER_W)) ||
                           (y_w < XW'(BORDER_W)) || (y_w >= XW'(V_DISP - BORDER_W));
        end
    endgenerate

    logic           act_q, brd_q, head_q, food_q, body_q, txt_q;
    logic [2:0]     bsel_q;
    logic [15:0]    pixel_q, pixel_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic           blink_q, blink_d;

    // Stage-2 priority mux; osd_q arrives aligned with the stage-1 flags.
    always_comb begin
        pixel_d = C_BG;
        if (!act_q)                      pixel_d = 16'h0000;
        else if (txt_q && osd_q[bsel_q]) pixel_d = C_TXT;
        else if (brd_q)                  pixel_d = C_BORDER;
        else if (head_q)                 pixel_d = C_HEAD;
        else if (body_q)                 pixel_d = C_BODY;
        else if (food_q)                 pixel_d = C_FOOD;
    end

    // Blink phase: parked visible while the game runs, so text shows immediately on fin.
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (!fin) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (tick_c) begin
            if (cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            act_q   <= 1'b0;
            brd_q   <= 1'b0;
            head_q  <= 1'b0;
            food_q  <= 1'b0;
            body_q  <= 1'b0;
            txt_q   <= 1'b0;
            bsel_q  <= 3'd0;
            pixel_q <= 16'h0000;
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            act_q   <= act_c;
            brd_q   <= brd_c;
            head_q  <= head_c;
            food_q  <= food_c;
            body_q  <= body_hit;
            txt_q   <= in_txt_c && fin && blink_q;
            bsel_q  <= 3'(3'd7 - b_c[2:0]);
            pixel_q <= pixel_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign pixel_data = pixel_q;
    assign blink_on   = blink_q;
endmodule

// File: tb/tb_snake_vga_compositor.sv
// Randomized bench for snake_vga_compositor against a screen-rule model,
// with directed pixels that carry hand-computed literal expectations.
module tb_snake_vga_compositor;
    localparam int BF = 2;
    localparam logic [15:0] BG = 16'hFFFF, HEAD = 16'h001F, BODY = 16'hF800,
                            FOOD = 16'h07E0, TXT = 16'h0000;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [10:0] px = '0, py = '0, hx = '0, hy = '0, fx = '0, fy = '0;
    logic        body_hit = 1'b0, fin = 1'b0;
    logic [10:0] osd_addr;
    logic [7:0]  osd_q;
    logic [15:0] pixel_data;
    logic        blink_on;

    logic [7:0]  rom [0:2047];
    int          vectors = 0, miscompares = 0;

    // Values the next drive() applies, so all inputs change together.
    bit          g_rst = 1'b1, g_fin = 1'b0;
    int          g_hx = 1500, g_hy = 1500, g_fx = 1600, g_fy = 1600;

    // Per-cycle literal expectations attached by drive().
    bit          lc_v = 1'b0, la_v = 1'b0, lb_v = 1'b0, lb = 1'b0;
    logic [15:0] lc = '0;
    logic [10:0] la = '0;

    logic [15:0] mq[$];
    logic [16:0] lq[$];
    int          nt = 0;

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) osd_q <= rom[osd_addr];

    snake_vga_compositor #(.BLINK_FRAMES(BF)) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst),
        .pixel_xpos(px), .pixel_ypos(py),
        .head_x(hx), .head_y(hy), .food_x(fx), .food_y(fy),
        .body_hit(body_hit), .fin(fin),
        .osd_addr(osd_addr), .osd_q(osd_q),
        .pixel_data(pixel_data), .blink_on(blink_on)
    );

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_win(int x, int y);
        return x >= 292 && x < 292 + 216 && y >= 168 && y < 168 + 64;
    endfunction

    function automatic int model_addr(int x, int y);
        if (!in_win(x, y)) return 0;
        return ((y - 168) * 216 + (x - 292)) / 8;
    endfunction

    function automatic logic [15:0] model_col(int x, int y, bit body, bit f, bit blk);
        logic [7:0] rb;
        int b;
        if (x >= 800 || y >= 600) return 16'h0000;
        if (f && blk && in_win(x, y)) begin
            b  = (y - 168) * 216 + (x - 292);
            rb = rom[b / 8];
            if (rb[7 - (b % 8)]) return TXT;
        end
        if (x >= int'(hx) && x < int'(hx) + 10 && y >= int'(hy) && y < int'(hy) + 10) return HEAD;
        if (body) return BODY;
        if (x >= int'(fx) && x < int'(fx) + 10 && y >= int'(fy) && y < int'(fy) + 10) return FOOD;
        return BG;
    endfunction

    // Single compare process: immediate ROM address and blink, pixel colour two cycles on.
    always @(negedge vga_clk) begin
        logic [15:0] e;
        logic [16:0] l;
        bit          mblk;
        mblk = ((nt / BF) % 2) == 0;
        check("osd_addr", {5'd0, osd_addr}, 16'(model_addr(int'(px), int'(py))));
        if (la_v) check("osd_addr_lit", {5'd0, osd_addr}, {5'd0, la});
        check("blink_on", {15'd0, blink_on}, {15'd0, mblk});
        if (lb_v) check("blink_on_lit", {15'd0, blink_on}, {15'd0, lb});
        if (sys_rst && mq.size() > 0) mq[mq.size() - 1] = 16'h0000;
        mq.push_back(sys_rst ? 16'h0000 : model_col(int'(px), int'(py), body_hit, fin, mblk));
        lq.push_back({lc_v, lc});
        if (mq.size() == 3) begin
            e = mq.pop_front();
            l = lq.pop_front();
            check("pixel_data", pixel_data, e);
            if (l[16]) check("pixel_data_lit", pixel_data, l[15:0]);
        end
        if (sys_rst || !fin) nt = 0;
        else if (px == 11'd799 && py == 11'd599) nt++;
    end

    task automatic drive(int x, int y, bit body, bit lcv = 0, logic [15:0] lcval = 0,
                         bit lav = 0, int laval = 0, bit lbv = 0, bit lbval = 0);
        @(posedge vga_clk);
        #1;
        sys_rst  = g_rst;
        fin      = g_fin;
        hx       = 11'(g_hx);
        hy       = 11'(g_hy);
        fx       = 11'(g_fx);
        fy       = 11'(g_fy);
        px       = 11'(x);
        py       = 11'(y);
        body_hit = body;
        lc_v     = lcv;
        lc       = lcval;
        la_v     = lav;
        la       = 11'(laval);
        lb_v     = lbv;
        lb       = lbval;
    endtask

    bit bexp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int r, x, y;
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        rom[0] = 8'b1000_0001;

        // Reset with coordinates sweeping, then a plain background pixel.
        g_rst = 1'b1;
        for (int i = 0; i < 3; i++)
            drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b0,
                  1, 16'h0000, 0, 0, 1, 1'b1);
        g_rst = 1'b0;
        drive(5, 5, 1'b0, 1, BG);

        // Head square edges on row 55.
        g_hx = 100; g_hy = 50; g_fx = 400; g_fy = 400;
        for (int i = 99; i <= 110; i++) drive(i, 55, 1'b0, 1, (i >= 100 && i <= 109) ? HEAD : BG);

        // Head at the right edge must not wrap to the left side.
        g_hx = 795;
        for (int i = 795; i <= 800; i++) drive(i, 55, 1'b0, 1, (i <= 799) ? HEAD : 16'h0000);
        for (int i = 0; i <= 4; i++) drive(i, 55, 1'b0, 1, BG);

        // Layer priority: body over food, head over body.
        g_hx = 100; g_fx = 200; g_fy = 200;
        drive(205, 205, 1'b1, 1, BODY);
        drive(105, 55, 1'b1, 1, HEAD);
        drive(205, 205, 1'b0, 1, FOOD);

        // Overlay bits of ROM byte 0 (MSB first) and the next byte address.
        g_fin = 1'b1;
        drive(292, 168, 1'b0, 1, TXT, 1, 0);
        drive(293, 168, 1'b0, 1, BG);
        drive(299, 168, 1'b0, 1, TXT);
        drive(300, 168, 1'b0, 0, 0, 1, 1);

        // Blink sequence over five frame ticks.
        for (int i = 0; i < 6; i++) begin
            drive(292, 168, 1'b0, 1, bexp[i] ? TXT : BG, 0, 0, 1, bexp[i]);
            if (i < 5) drive(799, 599, 1'b0);
        end
        drive(799, 599, 1'b0);
        drive(292, 168, 1'b0, 1, BG, 0, 0, 1, 1'b0);
        g_fin = 1'b0;
        drive(799, 599, 1'b0);
        drive(292, 168, 1'b0, 1, BG, 0, 0, 1, 1'b1);
        g_fin = 1'b1;
        drive(292, 168, 1'b0, 1, TXT, 0, 0, 1, 1'b1);
        drive(799, 599, 1'b0);
        drive(292, 168, 1'b0, 1, TXT, 0, 0, 1, 1'b1);
        drive(799, 599, 1'b0);
        drive(292, 168, 1'b0, 1, BG, 0, 0, 1, 1'b0);

        // Randomized traffic with occasional object moves, fin toggles and resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) g_fin = ~g_fin;
            g_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) begin
                g_hx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2030, 2047))
                                                   : int'($urandom_range(0, 810));
                g_hy = int'($urandom_range(0, 610));
                g_fx = int'($urandom_range(0, 810));
                g_fy = int'($urandom_range(0, 610));
            end
            r = int'($urandom_range(0, 4));
            case (r)
                0: begin x = int'($urandom_range(285, 515)); y = int'($urandom_range(160, 240)); end
                1: begin x = g_hx + int'($urandom_range(0, 15)) - 3; y = g_hy + int'($urandom_range(0, 15)) - 3; end
                2: begin x = g_fx + int'($urandom_range(0, 15)) - 3; y = g_fy + int'($urandom_range(0, 15)) - 3; end
                3: begin x = int'($urandom_range(0, 2047)); y = int'($urandom_range(0, 2047)); end
                default: begin x = 799; y = 599; end
            endcase
            drive(x, y, ($urandom_range(0, 3) == 0));
        end
        g_rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(5, 5, 1'b0);
        @(negedge vga_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
